// File: rtl/encode_eight_to_three_pkg.sv
// Shared definitions for the eight-to-three request encoder: widths,
// the presenter FSM encoding and a one-hot helper used to retire codes.
package encode_eight_to_three_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  // IDLE has nothing on the output; PRESENT holds a code until it is acked.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } stateT;

  // Expands a code into the single pending bit it retires.
  function automatic logic [REQ_W-1:0] oneHot(input logic [CODE_W-1:0] code);
    logic [REQ_W-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/encode_eight_to_three_prio.sv
// Combinational highest-index-first priority encoder over an 8-bit vector.
// Also reports whether any bit is set, so callers need no separate OR tree.
module prio_enc_eight
  import encode_eight_to_three_pkg::*;
(
  input  logic [REQ_W-1:0]  reqVec,
  output logic [CODE_W-1:0] code,
  output logic              anySet
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    code   = '0;
    anySet = |reqVec;
    for (int i = 0; i < REQ_W; i++) begin
      if (reqVec[i]) begin
        code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/encode_eight_to_three.sv
// Request collector and encoder. Pulses on iReq accumulate in a pending
// register; the FSM presents the highest pending index on oCode and holds
// it until the consumer acks, then moves straight on to the next pending
// index without a bubble. All outputs come straight from flops.
module encode_eight_to_three
  import encode_eight_to_three_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEnable,
  input  logic              iClear,
  input  logic [REQ_W-1:0]  iReq,
  input  logic              iAck,
  output logic              oValid,
  output logic [CODE_W-1:0] oCode,
  output logic [REQ_W-1:0]  oPending,
  output logic              oOverrun
);

  stateT             state;
  stateT             nextState;
  logic              validReg;
  logic              nextValid;
  logic [CODE_W-1:0] codeReg;
  logic [CODE_W-1:0] nextCode;
  logic [REQ_W-1:0]  pendReg;
  logic [REQ_W-1:0]  nextPend;
  logic              overrunReg;
  logic              nextOverrun;

  logic [REQ_W-1:0]  clrVec;
  logic [REQ_W-1:0]  pendMasked;
  logic [REQ_W-1:0]  acceptedReq;
  logic [CODE_W-1:0] pendCode;
  logic              pendAny;
  logic [CODE_W-1:0] maskedCode;
  logic              maskedAny;

  // Work out which bit an ack retires this cycle, what survives it, and
  // which new requests are allowed in. An ack with nothing presented
  // retires nothing.
  always_comb begin
    clrVec      = '0;
    if (validReg && iAck) begin
      clrVec = oneHot(codeReg);
    end
    pendMasked  = pendReg & ~clrVec;
    acceptedReq = iEnable ? iReq : '0;
  end

  // Encoder on the full pending set, used when leaving IDLE.
  prio_enc_eight uPendEnc (
    .reqVec (pendReg),
    .code   (pendCode),
    .anySet (pendAny)
  );

  // Encoder on the pending set after the ack, used for back-to-back
  // presentation. New requests are deliberately left out so they cannot
  // jump the queue on the ack cycle.
  prio_enc_eight uMaskedEnc (
    .reqVec (pendMasked),
    .code   (maskedCode),
    .anySet (maskedAny)
  );

  // Next-state, next-code and pending/overrun update. A request landing on
  // the same bit that is being retired is ORed back in after the clear, so
  // it is re-posted rather than lost. Clear wins over everything.
  always_comb begin
    nextState   = state;
    nextValid   = validReg;
    nextCode    = codeReg;
    nextPend    = pendMasked | acceptedReq;
    nextOverrun = overrunReg | (|(acceptedReq & pendMasked));

    if (iClear) begin
      nextState   = IDLE;
      nextValid   = 1'b0;
      nextPend    = '0;
      nextOverrun = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pendAny) begin
            nextState = PRESENT;
            nextValid = 1'b1;
            nextCode  = pendCode;
          end
        end
        PRESENT: begin
          if (iAck) begin
            if (maskedAny) begin
              nextState = PRESENT;
              nextValid = 1'b1;
              nextCode  = maskedCode;
            end else begin
              nextState = IDLE;
              nextValid = 1'b0;
            end
          end
        end
        default: begin
          nextState = IDLE;
          nextValid = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops everything immediately,
  // including any code that was mid-handshake.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      validReg   <= 1'b0;
      codeReg    <= '0;
      pendReg    <= '0;
      overrunReg <= 1'b0;
    end else begin
      state      <= nextState;
      validReg   <= nextValid;
      codeReg    <= nextCode;
      pendReg    <= nextPend;
      overrunReg <= nextOverrun;
    end
  end

  assign oValid   = validReg;
  assign oCode    = codeReg;
  assign oPending = pendReg;
  assign oOverrun = overrunReg;

endmodule

// File: tb/tb_encode_eight_to_three.sv
// Directed bench for encode_eight_to_three: each scenario task drives
// inputs just after a rising edge and checks the registered outputs 1ns
// after the following edge against hand-derived values.
module tb_encode_eight_to_three;

  logic       iClk;
  logic       iRst_n;
  logic       iEnable;
  logic       iClear;
  logic [7:0] iReq;
  logic       iAck;
  logic       oValid;
  logic [2:0] oCode;
  logic [7:0] oPending;
  logic       oOverrun;

  int vectors;
  int miscompares;

  logic [12:0] obsFull;
  logic [12:0] expFull;
  logic [9:0]  obsIdle;
  logic [9:0]  expIdle;

  encode_eight_to_three dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iEnable  (iEnable),
    .iClear   (iClear),
    .iReq     (iReq),
    .iAck     (iAck),
    .oValid   (oValid),
    .oCode    (oCode),
    .oPending (oPending),
    .oOverrun (oOverrun)
  );

  // 10ns clock.
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Full check {valid, code, pending, overrun} while a code is presented.
  task automatic checkFull(input string name, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic o);
    obsFull = {oValid, oCode, oPending, oOverrun};
    expFull = {v, c, p, o};
    vectors++;
    if (obsFull !== expFull) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%b c=%0d p=%h o=%b, expected v=%b c=%0d p=%h o=%b",
               name, oValid, oCode, oPending, oOverrun, v, c, p, o);
    end
  endtask

  // Check without oCode, which carries no meaning while oValid is low.
  task automatic checkIdle(input string name, input logic [7:0] p, input logic o);
    obsIdle = {oValid, oPending, oOverrun};
    expIdle = {1'b0, p, o};
    vectors++;
    if (obsIdle !== expIdle) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%b p=%h o=%b, expected v=0 p=%h o=%b",
               name, oValid, oPending, oOverrun, p, o);
    end
  endtask

  task automatic test_reset();
    iRst_n = 1'b0; iEnable = 1'b1; iClear = 1'b0; iReq = 8'h00; iAck = 1'b0;
    #12;
    checkFull("reset_held", 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge iClk);
    iRst_n = 1'b1;
    tick();
    checkFull("reset_released", 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic test_single();
    iReq = 8'h10; iAck = 1'b1;
    tick();
    checkIdle("single_posted", 8'h10, 1'b0);
    iReq = 8'h00;
    tick();
    checkFull("single_present", 1'b1, 3'd4, 8'h10, 1'b0);
    tick();
    checkIdle("single_retired", 8'h00, 1'b0);
    iAck = 1'b0;
  endtask

  task automatic test_multihot();
    iReq = 8'h85; iAck = 1'b1;
    tick();
    checkIdle("multi_posted", 8'h85, 1'b0);
    iReq = 8'h00;
    tick();
    checkFull("multi_code7", 1'b1, 3'd7, 8'h85, 1'b0);
    tick();
    checkFull("multi_code2", 1'b1, 3'd2, 8'h05, 1'b0);
    tick();
    checkFull("multi_code0", 1'b1, 3'd0, 8'h01, 1'b0);
    tick();
    checkIdle("multi_done", 8'h00, 1'b0);
    iAck = 1'b0;
  endtask

  task automatic test_stability();
    iReq = 8'h02; iAck = 1'b0;
    tick();
    iReq = 8'h00;
    tick();
    checkFull("stab_code1", 1'b1, 3'd1, 8'h02, 1'b0);
    iReq = 8'h40;
    tick();
    checkFull("stab_hold_on_higher", 1'b1, 3'd1, 8'h42, 1'b0);
    iReq = 8'h00;
    tick();
    checkFull("stab_hold_again", 1'b1, 3'd1, 8'h42, 1'b0);
    iAck = 1'b1;
    tick();
    checkFull("stab_next_code6", 1'b1, 3'd6, 8'h40, 1'b0);
    iAck = 1'b0;
    tick();
    checkFull("stab_code6_held", 1'b1, 3'd6, 8'h40, 1'b0);
    iAck = 1'b1;
    tick();
    checkIdle("stab_done", 8'h00, 1'b0);
    iAck = 1'b0;
  endtask

  task automatic test_overrun_repost();
    iReq = 8'h08;
    tick();
    checkIdle("ovr_posted", 8'h08, 1'b0);
    iReq = 8'h00;
    tick();
    checkFull("ovr_code3", 1'b1, 3'd3, 8'h08, 1'b0);
    iReq = 8'h08;
    tick();
    checkFull("ovr_flag_set", 1'b1, 3'd3, 8'h08, 1'b1);
    iAck = 1'b1;
    tick();
    checkIdle("ovr_repost_kept", 8'h08, 1'b1);
    iReq = 8'h00; iAck = 1'b0;
    tick();
    checkFull("ovr_represent", 1'b1, 3'd3, 8'h08, 1'b1);
    iAck = 1'b1;
    tick();
    checkIdle("ovr_drained_sticky", 8'h00, 1'b1);
    iAck = 1'b0;
  endtask

  task automatic test_enable_clear();
    iEnable = 1'b0; iReq = 8'hFF;
    tick();
    checkIdle("en_blocked", 8'h00, 1'b1);
    iEnable = 1'b1; iReq = 8'h81;
    tick();
    checkIdle("en_posted", 8'h81, 1'b1);
    iEnable = 1'b0; iReq = 8'hFF; iAck = 1'b1;
    tick();
    checkFull("en_off_present7", 1'b1, 3'd7, 8'h81, 1'b1);
    tick();
    checkFull("en_off_drain0", 1'b1, 3'd0, 8'h01, 1'b1);
    tick();
    checkIdle("en_off_drained", 8'h00, 1'b1);
    iEnable = 1'b1; iAck = 1'b0; iReq = 8'h03;
    tick();
    iReq = 8'h00;
    tick();
    checkFull("clr_present1", 1'b1, 3'd1, 8'h03, 1'b1);
    iClear = 1'b1; iAck = 1'b1; iReq = 8'hFF;
    tick();
    checkIdle("clr_flush", 8'h00, 1'b0);
    iClear = 1'b0; iAck = 1'b0; iReq = 8'h00;
    tick();
    checkIdle("clr_stays_idle", 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_present();
    iReq = 8'h3C;
    tick();
    iReq = 8'h00;
    tick();
    checkFull("rst_pre_present5", 1'b1, 3'd5, 8'h3C, 1'b0);
    #2;
    iRst_n = 1'b0;
    #1;
    checkFull("rst_async_zero", 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge iClk);
    iRst_n = 1'b1;
    tick();
    checkFull("rst_nothing_survives", 1'b0, 3'd0, 8'h00, 1'b0);
    iReq = 8'h01;
    tick();
    checkIdle("rst_first_posted", 8'h01, 1'b0);
    iReq = 8'h00;
    tick();
    checkFull("rst_first_present", 1'b1, 3'd0, 8'h01, 1'b0);
    iAck = 1'b1;
    tick();
    checkIdle("rst_first_done", 8'h00, 1'b0);
    iAck = 1'b0;
  endtask

  // Scenarios run in order; each leaves the DUT idle for the next.
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_multihot();
    test_stability();
    test_overrun_repost();
    test_enable_clear();
    test_reset_mid_present();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
